// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen
//   Mechanical-switch emulator. On each requested transition it drives a
//   bouncing output: N_BOUNCE pairs of a short "contact" pulse at the new
//   level followed by a longer "release" pause at the old level. After the
//   last pause the output settles at the new level. Pulse and pause lengths
//   come from a 16-bit Galois LFSR, so a given SEED always produces the
//   same waveform.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous reset, active low
//   req_vld  in   transition request valid
//   req_val  in   requested final switch level
//   abort    in   (only with SWITCH_BOUNCE_GEN_ABORT_EN) stop bouncing, settle now
//   req_rdy  out  idle, a request is accepted this cycle if req_vld=1
//   d_o      out  bouncing switch output
//   busy     out  high while bouncing
//   done     out  one-cycle pulse when d_o has settled
//
// Optional feature
//   SWITCH_BOUNCE_GEN_ABORT_EN : adds the abort input.

module switch_bounce_gen #(
  parameter int unsigned CW        = 16,
  parameter int unsigned N_BOUNCE  = 80,
  parameter int unsigned PULSE_MIN = 1,
  parameter int unsigned PULSE_LW  = 5,
  parameter int unsigned PAUSE_MIN = 50,
  parameter int unsigned PAUSE_LW  = 10,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic        INIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_vld,
  input  logic req_val,
`ifdef SWITCH_BOUNCE_GEN_ABORT_EN
  input  logic abort,
`endif
  output logic req_rdy,
  output logic d_o,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, PULSE, PAUSE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_adv;
  logic [15:0]   pair;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pulse_len;
  logic [CW-1:0] pause_len;
  logic          tgt;
  logic          abort_hit;

  // Galois LFSR, right shift, taps 16'hB400.
  assign lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Durations use the current LFSR value; the LFSR advances on the same edge.
  generate
    if (PULSE_LW == 0) begin : gen_pulse_fixed
      assign pulse_len = CW'(PULSE_MIN);
    end else begin : gen_pulse_rand
      assign pulse_len = CW'(PULSE_MIN) + CW'(lfsr[PULSE_LW-1:0]);
    end
    if (PAUSE_LW == 0) begin : gen_pause_fixed
      assign pause_len = CW'(PAUSE_MIN);
    end else begin : gen_pause_rand
      assign pause_len = CW'(PAUSE_MIN) + CW'(lfsr[PAUSE_LW-1:0]);
    end
  endgenerate

`ifdef SWITCH_BOUNCE_GEN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign req_rdy = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      d_o   <= INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
      lfsr  <= SEED_EFF;
      pair  <= 16'd0;
      cnt   <= '0;
      tgt   <= INIT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            tgt <= req_val;
            if (req_val == d_o) begin
              // Already at the requested level: report settled, no bounce.
              done <= 1'b1;
            end else begin
              d_o   <= req_val;
              busy  <= 1'b1;
              state <= PULSE;
              pair  <= 16'd1;
              cnt   <= pulse_len;
              lfsr  <= lfsr_adv;
            end
          end
        end

        PULSE: begin
          if (abort_hit) begin
            d_o   <= tgt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CW'(1)) begin
            // Last cycle of the contact pulse: open the contact.
            cnt   <= pause_len;
            lfsr  <= lfsr_adv;
            d_o   <= ~tgt;
            state <= PAUSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        PAUSE: begin
          if (abort_hit) begin
            d_o   <= tgt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CW'(1)) begin
            if (pair == 16'(N_BOUNCE)) begin
              d_o   <= tgt;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              pair  <= pair + 16'd1;
              cnt   <= pulse_len;
              lfsr  <= lfsr_adv;
              d_o   <= tgt;
              state <= PULSE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Testbench for switch_bounce_gen.
//   dut   : deterministic configuration (N_BOUNCE=3, pulse 2, pause 5, SEED=0)
//           driven from a per-cycle vector table.
//   dut_r : small randomized configuration checked against an LFSR model,
//           run twice from reset to confirm the waveform repeats.

module tb_switch_bounce_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic req_vld = 1'b0;
  logic req_val = 1'b0;
  logic abort   = 1'b0;
  logic req_rdy, d_o, busy, done;

  logic req_vld_r = 1'b0;
  logic req_val_r = 1'b0;
  logic abort_r   = 1'b0;
  logic req_rdy_r, d_o_r, busy_r, done_r;

  int vectors     = 0;
  int miscompares = 0;

  switch_bounce_gen #(
    .CW(16), .N_BOUNCE(3), .PULSE_MIN(2), .PULSE_LW(0),
    .PAUSE_MIN(5), .PAUSE_LW(0), .SEED(16'h0000), .INIT(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_val(req_val),
`ifdef SWITCH_BOUNCE_GEN_ABORT_EN
    .abort(abort),
`endif
    .req_rdy(req_rdy), .d_o(d_o), .busy(busy), .done(done)
  );

  switch_bounce_gen #(
    .CW(16), .N_BOUNCE(4), .PULSE_MIN(1), .PULSE_LW(3),
    .PAUSE_MIN(6), .PAUSE_LW(3), .SEED(16'hACE1), .INIT(1'b0)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld_r), .req_val(req_val_r),
`ifdef SWITCH_BOUNCE_GEN_ABORT_EN
    .abort(abort_r),
`endif
    .req_rdy(req_rdy_r), .d_o(d_o_r), .busy(busy_r), .done(done_r)
  );

  typedef struct {
    logic rst_n;
    logic vld;
    logic val;
    logic ab;
    logic d;
    logic dn;
    logic bsy;
    logic rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic x,
                              input logic a, input logic d, input logic dn,
                              input logic b, input logic rd);
    vec_t e;
    e.rst_n = r; e.vld = v; e.val = x; e.ab = a;
    e.d = d; e.dn = dn; e.bsy = b; e.rdy = rd;
    tbl.push_back(e);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Counts consecutive cycles with d_o_r at lvl; leaves the sample on the
  // first cycle at the other level.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (d_o_r === lvl && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random(input int run, output int sig);
    logic [15:0] m;
    logic        tgt;
    int          n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m   = 16'hACE1;
    tgt = 1'b0;
    sig = 0;
    for (int t = 0; t < 10; t++) begin
      tgt = ~tgt;
      req_vld_r = 1'b1;
      req_val_r = tgt;
      @(posedge clk); #1;
      req_vld_r = 1'b0;
      for (int p = 1; p <= 4; p++) begin
        int exp_len;
        exp_len = 1 + int'(m[2:0]);
        m = lfsr_step(m);
        measure(tgt, n);
        chk($sformatf("run%0d t%0d pulse%0d len", run, t, p), n, exp_len);
        sig = sig * 31 + n;
        exp_len = 6 + int'(m[2:0]);
        m = lfsr_step(m);
        measure(~tgt, n);
        chk($sformatf("run%0d t%0d pause%0d len", run, t, p), n, exp_len);
        sig = sig * 31 + n;
      end
      chk($sformatf("run%0d t%0d settle d_o,done,rdy", run, t),
          int'({d_o_r, done_r, req_rdy_r}), int'({tgt, 1'b1, 1'b1}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sig1, sig2;

    // Reset held for 3 cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset d_o,done,busy,rdy", int'({d_o, done, busy, req_rdy}), 4'b0001);
    chk("reset lfsr (seed 0)", int'(dut.lfsr), 16'h0001);

    // Same-level request from d_o=0.
    add(1, 1, 0, 0,  0, 1, 0, 1);
    add(1, 0, 0, 0,  0, 0, 0, 1);
    // Bounce to 1; req_vld held high with val=0 throughout, must be ignored.
    add(1, 1, 1, 0,  1, 0, 1, 0);                     // T+1
    for (int c = 2; c <= 21; c++) begin
      int p;
      p = (c - 1) % 7;
      add(1, 1, 0, 0,  logic'(p < 2), 0, 1, 0);        // T+2..T+21
    end
    add(1, 1, 0, 0,  1, 1, 0, 1);                     // T+22 settled, done
    add(1, 0, 0, 0,  1, 0, 0, 1);
    // Bounce to 0, reset during the first pause.
    add(1, 1, 0, 0,  0, 0, 1, 0);                     // pulse
    add(1, 0, 0, 0,  0, 0, 1, 0);                     // pulse
    add(1, 0, 0, 0,  1, 0, 1, 0);                     // pause
    add(0, 0, 0, 0,  0, 0, 0, 1);                     // reset: back to INIT
    add(1, 0, 0, 0,  0, 0, 0, 1);                     // no done pulse
    add(1, 0, 0, 0,  0, 0, 0, 1);
`ifdef SWITCH_BOUNCE_GEN_ABORT_EN
    // Abort during the second pulse of a val=1 transition.
    add(1, 1, 1, 0,  1, 0, 1, 0);                     // T+1
    for (int c = 2; c <= 8; c++) begin
      int p;
      p = (c - 1) % 7;
      add(1, 0, 0, 0,  logic'(p < 2), 0, 1, 0);        // T+2..T+8
    end
    add(1, 0, 0, 1,  1, 1, 0, 1);                     // T+9 after abort
    add(1, 0, 0, 0,  1, 0, 0, 1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n   = tbl[i].rst_n;
      req_vld = tbl[i].vld;
      req_val = tbl[i].val;
      abort   = tbl[i].ab;
      @(posedge clk); #1;
      vectors++;
      if ({d_o, done, busy, req_rdy} !== {tbl[i].d, tbl[i].dn, tbl[i].bsy, tbl[i].rdy}) begin
        miscompares++;
        $display("FAIL vec%0d d_o,done,busy,rdy: got %b%b%b%b expected %b%b%b%b", i,
                 d_o, done, busy, req_rdy, tbl[i].d, tbl[i].dn, tbl[i].bsy, tbl[i].rdy);
      end else begin
        $display("ok   vec%0d d_o,done,busy,rdy = %b%b%b%b", i, d_o, done, busy, req_rdy);
      end
    end
    req_vld = 1'b0;
    abort   = 1'b0;

    run_random(1, sig1);
    run_random(2, sig2);
    chk("repeatable trace signature", sig2, sig1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
